// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and constants for the 111010 sequence detector
package seq_det_pkg;

    localparam logic [5:0] PATTERN = 6'b111010;

    typedef enum logic [2:0] {
        CORE_IDLE,
        CORE_S1,
        CORE_S11,
        CORE_S111,
        CORE_S1110,
        CORE_S11101
    } core_state_t;

    typedef enum logic {
        CTRL_IDLE,
        CTRL_SHIFT
    } ctrl_state_t;

endpackage

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - Mealy 111010 non-overlapping detector core, one bit per enabled cycle
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic bit_en,
    input  logic clear,
    output logic match
);

    core_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CORE_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        match     = 1'b0;
        if (clear) begin
            state_nxt = CORE_IDLE;
        end else if (bit_en) begin
            unique case (state)
                CORE_IDLE:   state_nxt = bit_in ? CORE_S1     : CORE_IDLE;
                CORE_S1:     state_nxt = bit_in ? CORE_S11    : CORE_IDLE;
                CORE_S11:    state_nxt = bit_in ? CORE_S111   : CORE_IDLE;
                CORE_S111:   state_nxt = bit_in ? CORE_S111   : CORE_S1110;
                CORE_S1110:  state_nxt = bit_in ? CORE_S11101 : CORE_IDLE;
                CORE_S11101: begin
                    // A completed match restarts from IDLE so matches never share bits.
                    state_nxt = bit_in ? CORE_S11 : CORE_IDLE;
                    match     = !bit_in;
                end
                default:     state_nxt = CORE_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - word-fed 111010 detector controller; SEQ_CTRL_POS_CAPTURE_EN adds last_pos
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             flush,
    input  logic [CNT_W-1:0] thresh,
    input  logic             irq_clr,
    output logic             det_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
`ifdef SEQ_CTRL_POS_CAPTURE_EN
    output logic [$clog2(W)-1:0] last_pos,
`endif
    output logic             irq
);

    localparam int IDX_W = $clog2(W);

    ctrl_state_t      state, state_nxt;
    logic [W-1:0]     shreg;
    logic [IDX_W-1:0] idx;
    logic             last_bit;
    logic             accept;
    logic             bit_en;
    logic             match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CTRL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The last SHIFT cycle also offers ready so back-to-back words leave no bubble.
    always_comb begin
        state_nxt  = state;
        last_bit   = (state == CTRL_SHIFT) && (idx == IDX_W'(W - 1));
        busy       = (state == CTRL_SHIFT);
        word_ready = !flush && ((state == CTRL_IDLE) || last_bit);
        accept     = word_valid && word_ready;
        bit_en     = (state == CTRL_SHIFT) && !flush;
        if (flush) begin
            state_nxt = CTRL_IDLE;
        end else if (accept) begin
            state_nxt = CTRL_SHIFT;
        end else if (last_bit) begin
            state_nxt = CTRL_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            idx   <= '0;
        end else if (accept) begin
            shreg <= word_in;
            idx   <= '0;
        end else if (bit_en) begin
            shreg <= {shreg[W-2:0], 1'b0};
            idx   <= idx + IDX_W'(1);
        end
    end

    seq_det_core u_core (
        .clk    (clk),
        .rst    (rst),
        .bit_in (shreg[W-1]),
        .bit_en (bit_en),
        .clear  (flush),
        .match  (match)
    );

    // irq compares against the registered count, so it trails match_cnt by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_pulse <= 1'b0;
            match_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            det_pulse <= match;
            if (irq_clr) begin
                match_cnt <= match ? CNT_W'(1) : '0;
            end else if (match && (match_cnt != '1)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
            if (irq_clr) begin
                irq <= 1'b0;
            end else if ((thresh != '0) && (match_cnt >= thresh)) begin
                irq <= 1'b1;
            end
        end
    end

`ifdef SEQ_CTRL_POS_CAPTURE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pos <= '0;
        end else if (match) begin
            last_pos <= idx;
        end
    end
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - self-checking bench for seq_det_ctrl with a bit-window reference model
module tb_seq_det_ctrl;
    import seq_det_pkg::*;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] word_in = '0;
    logic       word_valid = 1'b0;
    logic       word_ready;
    logic       flush = 1'b0;
    logic [7:0] thresh = '0;
    logic       irq_clr = 1'b0;
    logic       det_pulse;
    logic [7:0] match_cnt;
    logic       busy;
    logic       irq;
`ifdef SEQ_CTRL_POS_CAPTURE_EN
    logic [2:0] last_pos;
`endif

    seq_det_ctrl #(.W(W), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .flush      (flush),
        .thresh     (thresh),
        .irq_clr    (irq_clr),
        .det_pulse  (det_pulse),
        .match_cnt  (match_cnt),
        .busy       (busy),
`ifdef SEQ_CTRL_POS_CAPTURE_EN
        .last_pos   (last_pos),
`endif
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a match is six consecutive presented bits equal to PATTERN, counted
    // from the last reset, flush or match (the window restarts after each).
    int         m_left = 0;
    int         m_pos = 0;
    logic [7:0] m_word = '0;
    int         m_run = 0;
    logic [5:0] m_win = '0;
    logic       m_det = 1'b0;
    logic [7:0] m_cnt = '0;
    logic       m_irq = 1'b0;
    int         m_last = 0;
    logic       m_hit;
    logic       m_rdy;
    int         m_hpos;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0; m_pos = 0; m_run = 0; m_win = '0;
            m_det = 1'b0; m_cnt = '0; m_irq = 1'b0; m_last = 0;
        end else begin
            m_hit  = 1'b0;
            m_hpos = 0;
            m_rdy  = !flush && (m_left <= 1);
            if (flush) begin
                m_left = 0; m_run = 0; m_win = '0;
            end else if (m_left > 0) begin
                m_win = {m_win[4:0], m_word[W-1-m_pos]};
                m_run++;
                if (m_run >= 6 && m_win == PATTERN) begin
                    m_hit = 1'b1; m_hpos = m_pos; m_run = 0; m_win = '0;
                end
                m_pos++;
                m_left--;
            end
            if (word_valid && m_rdy) begin
                m_word = word_in; m_pos = 0; m_left = W;
            end
            if (irq_clr) m_irq = 1'b0;
            else if (thresh != 0 && m_cnt >= thresh) m_irq = 1'b1;
            if (irq_clr) m_cnt = m_hit ? 8'd1 : 8'd0;
            else if (m_hit && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            m_det = m_hit;
            if (m_hit) m_last = m_hpos;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("word_ready", word_ready, (!flush && m_left <= 1));
            check("busy", busy, (m_left > 0));
            check("det_pulse", det_pulse, m_det);
            check("match_cnt", match_cnt, m_cnt);
            check("irq", irq, m_irq);
`ifdef SEQ_CTRL_POS_CAPTURE_EN
            check("last_pos", last_pos, m_last);
`endif
        end
    end

    // Pulse log: stamp k means the pulse was seen in cycle N+k for an accept at edge N.
    int cyc_cnt = 0;
    int plog[$];
    int pos_log[$];

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (det_pulse) begin
            plog.push_back(cyc_cnt + 1);
`ifdef SEQ_CTRL_POS_CAPTURE_EN
            pos_log.push_back(int'(last_pos));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, output int c0);
        word_in    = w;
        word_valid = 1'b1;
        tick();
        c0         = cyc_cnt;
        word_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    int c0;
    int c1;

    initial begin
        repeat (2) tick();
        chk_en = 1'b1;
        tick();
        check("reset_ready", word_ready, 1);
        check("reset_cnt", match_cnt, 0);
        rst = 1'b1;
        tick();

        // Single matching word
        plog.delete(); pos_log.delete();
        send(8'b1110_1000, c0);
        repeat (10) tick();
        check("t1_npulse", plog.size(), 1);
        if (plog.size() >= 1) check("t1_latency", plog[0] - c0, 7);
        check("t1_cnt", match_cnt, 1);
`ifdef SEQ_CTRL_POS_CAPTURE_EN
        check("t1_pos", last_pos, 5);
`endif

        // Back-to-back, pattern straddling words
        plog.delete(); pos_log.delete();
        word_in = 8'b0000_0111; word_valid = 1'b1;
        tick();
        c0 = cyc_cnt;
        word_in = 8'b0100_0000;
        repeat (7) @(posedge clk);
        #1;
        @(negedge clk);
        check("t2_ready_last", word_ready, 1);
        check("t2_busy_last", busy, 1);
        tick();
        c1 = cyc_cnt;
        word_valid = 1'b0;
        repeat (10) tick();
        check("t2_accept_gap", c1 - c0, 8);
        check("t2_npulse", plog.size(), 1);
        if (plog.size() >= 1) check("t2_latency", plog[0] - c1, 4);
`ifdef SEQ_CTRL_POS_CAPTURE_EN
        if (pos_log.size() >= 1) check("t2_pos", pos_log[0], 2);
`endif

        // Non-overlap across 11101011 / 10100000
        plog.delete(); pos_log.delete();
        word_in = 8'b1110_1011; word_valid = 1'b1;
        tick();
        c0 = cyc_cnt;
        word_in = 8'b1010_0000;
        repeat (8) @(posedge clk);
        #1;
        word_valid = 1'b0;
        repeat (12) tick();
        check("t3_npulse", plog.size(), 2);
        if (plog.size() >= 2) begin
            check("t3_first", plog[0] - c0, 7);
            check("t3_second", plog[1] - c0, 13);
        end
`ifdef SEQ_CTRL_POS_CAPTURE_EN
        if (pos_log.size() >= 2) begin
            check("t3_pos0", pos_log[0], 5);
            check("t3_pos1", pos_log[1], 3);
        end
`endif

        // Flush after three bits
        plog.delete(); pos_log.delete();
        send(8'b1110_1000, c0);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("t4_ready_flush", word_ready, 0);
        tick();
        flush = 1'b0;
        check("t4_busy_after", busy, 0);
        repeat (10) tick();
        check("t4_npulse_flushed", plog.size(), 0);
        send(8'b1110_1000, c0);
        repeat (10) tick();
        check("t4_npulse_after", plog.size(), 1);
        if (plog.size() >= 1) check("t4_latency", plog[0] - c0, 7);

        // Threshold interrupt and coincident clear
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        thresh = 8'd2;
        send(8'b1110_1000, c0);
        repeat (9) tick();
        send(8'b1110_1000, c0);
        repeat (6) @(posedge clk);
        #1;
        check("t5_cnt2", match_cnt, 2);
        check("t5_irq_not_yet", irq, 0);
        tick();
        check("t5_irq_rise", irq, 1);
        repeat (3) tick();
        send(8'b1110_1000, c0);
        repeat (5) @(posedge clk);
        #1;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("t5_clr_pulse", det_pulse, 1);
        check("t5_clr_cnt", match_cnt, 1);
        check("t5_clr_irq", irq, 0);
        tick();
        check("t5_clr_irq_next", irq, 0);
        repeat (3) tick();

        // Reset mid-shift
        send(8'b1110_1000, c0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_ready", word_ready, 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_det", det_pulse, 0);
        check("t6_rst_cnt", match_cnt, 0);
        check("t6_rst_irq", irq, 0);
        tick();
        rst = 1'b1;
        repeat (3) tick();

        // Saturation
        thresh = 8'd0;
        word_in = 8'b1110_1000; word_valid = 1'b1;
        repeat (260 * 8) @(posedge clk);
        #1;
        word_valid = 1'b0;
        repeat (12) tick();
        check("t7_saturate", match_cnt, 255);
        check("t7_irq_disabled", irq, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
